// File: rtl/booth_seq_accum.sv
// Sequential radix-4 Booth multiplier: signed 32x32 -> 64, one Booth digit
// per cycle into a 64-bit accumulator, with valid/ready handshakes on both sides.
module booth_seq_accum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] xin,
  input  logic [31:0] yin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] x_q, x_d;
  logic [32:0] y_q, y_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] product_q, product_d;

  logic [63:0] pp;
  logic [63:0] sum;

  // Booth digit decode of the low three multiplier bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    pp = '0;
    case (y_q[2:0])
      3'b001, 3'b010: pp = x_q;
      3'b011:         pp = x_q << 1;
      3'b100:         pp = ~(x_q << 1) + 64'd1;
      3'b101, 3'b110: pp = ~x_q + 64'd1;
      default:        pp = '0;
    endcase
  end

  assign sum = acc_q + pp;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
        if (in_valid) begin
          state_d = RUN;
          x_d     = {{32{xin[31]}}, xin};
          y_d     = {yin, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = sum;
        x_d   = x_q << 2;
        y_d   = {{2{y_q[32]}}, y_q[32:2]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          product_d = sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, so an aborted operation leaves nothing behind and product reads 0.
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule
